// File: rtl/matrix_loader_pkg.sv
// Shared types for the matrix loader: control codes, FSM states, error codes.
package matrix_loader_pkg;

    typedef enum logic [1:0] {
        CTRL_DATA  = 2'd0,
        CTRL_DIM   = 2'd1,
        CTRL_IDLE  = 2'd2,
        CTRL_ABORT = 2'd3
    } ctrl_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIM    = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_HOLD   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_MISMATCH = 2'd2,
        ERR_PROTO    = 2'd3
    } err_e;

    // A dimension is usable when it is nonzero and fits the storage.
    function automatic logic dim_in_range(input int unsigned d, input int unsigned max_dim);
        return (d != 0) && (d <= max_dim);
    endfunction

endpackage

// File: rtl/loader_rc_counter.sv
// Row/column walker for one matrix: produces the row-major storage index of the
// current element and a done pulse when the last element of the RxC region is taken.
module loader_rc_counter #(
    parameter int MAX_DIM = 4,
    localparam int DIMW = $clog2(MAX_DIM + 1),
    localparam int NE   = MAX_DIM * MAX_DIM,
    localparam int IW   = (NE > 1) ? $clog2(NE) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            clr,
    input  logic            en,
    input  logic [DIMW-1:0] row_lim,
    input  logic [DIMW-1:0] col_lim,
    output logic [IW-1:0]   idx,
    output logic            done
);
    localparam int CW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic          col_last, row_last;

    assign col_last = (DIMW'(col_q) == col_lim - 1'b1);
    assign row_last = (DIMW'(row_q) == row_lim - 1'b1);
    assign idx      = IW'(row_q) * IW'(MAX_DIM) + IW'(col_q);
    assign done     = en && !clr && col_last && row_last;

    // Advance column on each accepted element, wrapping into the next row.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/matrix_loader_hs.sv
// Matrix loader: takes a 4-word dimension header then A and B elements row-major,
// validates the header, and holds both matrices behind a valid/ready handshake.
module matrix_loader_hs
    import matrix_loader_pkg::*;
#(
    parameter int DW      = 8,
    parameter int MAX_DIM = 4,
    localparam int DIMW   = $clog2(MAX_DIM + 1)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [1:0]                  ctrl,
    input  logic [DW-1:0]               data_in,
    output logic                        in_ready,
    output logic [MAX_DIM*MAX_DIM*DW-1:0] mat_a,
    output logic [MAX_DIM*MAX_DIM*DW-1:0] mat_b,
    output logic [DIMW-1:0]             r1,
    output logic [DIMW-1:0]             c1,
    output logic [DIMW-1:0]             r2,
    output logic [DIMW-1:0]             c2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        err,
    output logic [1:0]                  err_code
);
    localparam int NE = MAX_DIM * MAX_DIM;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;

    ctrl_e                   cmd;
    state_e                  state_q, state_d;
    logic [NE-1:0][DW-1:0]   mat_a_q, mat_a_d, mat_b_q, mat_b_d;
    logic [DIMW-1:0]         r1_q, r1_d, c1_q, c1_d, r2_q, r2_d, c2_q, c2_d;
    logic [1:0]              hdr_cnt_q, hdr_cnt_d;
    err_e                    err_code_q, err_code_d, hdr_code;
    logic [DIMW-1:0]         data_dim;
    logic [IW-1:0]           a_idx, b_idx;
    logic                    a_en, b_en, a_done, b_done, cnt_clr;

    assign cmd      = ctrl_e'(ctrl);
    assign data_dim = data_in[DIMW-1:0];

    // Counters idle at zero outside a load and are flushed by ABORT.
    assign cnt_clr = (state_q == ST_IDLE) || (cmd == CTRL_ABORT);
    assign a_en    = (state_q == ST_LOAD_A) && (cmd == CTRL_DATA);
    assign b_en    = (state_q == ST_LOAD_B) && (cmd == CTRL_DATA);

    loader_rc_counter #(.MAX_DIM(MAX_DIM)) u_cnt_a (
        .CLK(CLK), .RST(RST), .clr(cnt_clr), .en(a_en),
        .row_lim(r1_q), .col_lim(c1_q), .idx(a_idx), .done(a_done)
    );

    loader_rc_counter #(.MAX_DIM(MAX_DIM)) u_cnt_b (
        .CLK(CLK), .RST(RST), .clr(cnt_clr), .en(b_en),
        .row_lim(r2_q), .col_lim(c2_q), .idx(b_idx), .done(b_done)
    );

    // Header verdict evaluated as the 4th word (C2) arrives; range beats mismatch.
    always_comb begin
        hdr_code = ERR_NONE;
        if (!dim_in_range(32'(r1_q), MAX_DIM) || !dim_in_range(32'(c1_q), MAX_DIM) ||
            !dim_in_range(32'(r2_q), MAX_DIM) || !dim_in_range(32'(data_dim), MAX_DIM))
            hdr_code = ERR_RANGE;
        else if (c1_q != r2_q)
            hdr_code = ERR_MISMATCH;
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd == CTRL_DIM) state_d = ST_DIM;
            ST_DIM: begin
                if (cmd == CTRL_ABORT)      state_d = ST_IDLE;
                else if (cmd != CTRL_DIM)   state_d = ST_ERR;
                else if (hdr_cnt_q == 2'd3) state_d = (hdr_code == ERR_NONE) ? ST_LOAD_A : ST_ERR;
            end
            ST_LOAD_A: begin
                if (cmd == CTRL_ABORT)      state_d = ST_IDLE;
                else if (cmd == CTRL_DIM)   state_d = ST_ERR;
                else if (a_done)            state_d = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                if (cmd == CTRL_ABORT)      state_d = ST_IDLE;
                else if (cmd == CTRL_DIM)   state_d = ST_ERR;
                else if (b_done)            state_d = ST_HOLD;
            end
            // A handshake and an ABORT both release the held result.
            ST_HOLD:   if (out_ready || cmd == CTRL_ABORT) state_d = ST_IDLE;
            ST_ERR:    if (cmd == CTRL_ABORT) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: header capture, element writes, error code.
    always_comb begin
        mat_a_d    = mat_a_q;
        mat_b_d    = mat_b_q;
        r1_d       = r1_q;
        c1_d       = c1_q;
        r2_d       = r2_q;
        c2_d       = c2_q;
        hdr_cnt_d  = hdr_cnt_q;
        err_code_d = err_code_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd == CTRL_DIM) begin
                    r1_d      = data_dim;
                    mat_a_d   = '0;
                    mat_b_d   = '0;
                    hdr_cnt_d = 2'd1;
                end
            end
            ST_DIM: begin
                if (cmd == CTRL_DIM) begin
                    case (hdr_cnt_q)
                        2'd1:    c1_d = data_dim;
                        2'd2:    r2_d = data_dim;
                        default: c2_d = data_dim;
                    endcase
                    // Wraps back to 0 after the 4th header word.
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) err_code_d = hdr_code;
                end else begin
                    hdr_cnt_d = '0;
                    if (cmd != CTRL_ABORT) err_code_d = ERR_PROTO;
                end
            end
            ST_LOAD_A: begin
                if (cmd == CTRL_DATA)     mat_a_d[a_idx] = data_in;
                else if (cmd == CTRL_DIM) err_code_d = ERR_PROTO;
            end
            ST_LOAD_B: begin
                if (cmd == CTRL_DATA)     mat_b_d[b_idx] = data_in;
                else if (cmd == CTRL_DIM) err_code_d = ERR_PROTO;
            end
            ST_ERR: if (cmd == CTRL_ABORT) err_code_d = ERR_NONE;
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mat_a_q    <= '0;
            mat_b_q    <= '0;
            r1_q       <= '0;
            c1_q       <= '0;
            r2_q       <= '0;
            c2_q       <= '0;
            hdr_cnt_q  <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            mat_a_q    <= mat_a_d;
            mat_b_q    <= mat_b_d;
            r1_q       <= r1_d;
            c1_q       <= c1_d;
            r2_q       <= r2_d;
            c2_q       <= c2_d;
            hdr_cnt_q  <= hdr_cnt_d;
            err_code_q <= err_code_d;
        end
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        in_ready  = state_q inside {ST_IDLE, ST_DIM, ST_LOAD_A, ST_LOAD_B};
        out_valid = (state_q == ST_HOLD);
        err       = (err_code_q != ERR_NONE);
    end

    assign mat_a    = mat_a_q;
    assign mat_b    = mat_b_q;
    assign r1       = r1_q;
    assign c1       = c1_q;
    assign r2       = r2_q;
    assign c2       = c2_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_matrix_loader_hs.sv
// Scoreboard bench for matrix_loader_hs: stimulus pushes expected results, a
// negedge monitor pops and compares whenever out_valid or err rises.
module tb_matrix_loader_hs;
    import matrix_loader_pkg::*;

    localparam int DW   = 8;
    localparam int MD   = 4;
    localparam int DIMW = 3;
    localparam int FW   = MD * MD * DW;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [1:0]      ctrl;
    logic [DW-1:0]   data_in;
    logic            in_ready, out_valid, out_ready, err;
    logic [FW-1:0]   mat_a, mat_b;
    logic [DIMW-1:0] r1, c1, r2, c2;
    logic [1:0]      err_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [FW-1:0]     a;
        logic [FW-1:0]     b;
        logic [4*DIMW-1:0] dims;
    } exp_t;

    exp_t       exp_out[$];
    logic [1:0] exp_err[$];
    bit         mon_pv, mon_pe;

    matrix_loader_hs #(.DW(DW), .MAX_DIM(MD)) dut (
        .CLK(CLK), .RST(RST), .ctrl(ctrl), .data_in(data_in), .in_ready(in_ready),
        .mat_a(mat_a), .mat_b(mat_b), .r1(r1), .c1(c1), .r2(r2), .c2(c2),
        .out_valid(out_valid), .out_ready(out_ready), .err(err), .err_code(err_code)
    );

    always #5 CLK = ~CLK;

    task automatic checkw(input string name, input logic [FW-1:0] got, input logic [FW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic checkn(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Expected storage image: element i of an r x c region lands at row-major slot.
    function automatic logic [FW-1:0] build(input int r, input int c, input int base);
        logic [FW-1:0] v;
        v = '0;
        for (int i = 0; i < r * c; i++) v[((i / c) * MD + (i % c)) * DW +: DW] = DW'(base + i);
        return v;
    endfunction

    // Called at posedge+1; the word is sampled at the next posedge.
    task automatic send(input ctrl_e c, input int d);
        ctrl    = c;
        data_in = DW'(d);
        @(posedge CLK);
        #1;
        ctrl = CTRL_IDLE;
    endtask

    task automatic hdr(input int a, input int b, input int c, input int d);
        send(CTRL_DIM, a);
        send(CTRL_DIM, b);
        send(CTRL_DIM, c);
        send(CTRL_DIM, d);
    endtask

    task automatic load(input int r1v, input int c1v, input int r2v, input int c2v,
                        input int abase, input int bbase, input int gap_at);
        exp_t e;
        e.a    = build(r1v, c1v, abase);
        e.b    = build(r2v, c2v, bbase);
        e.dims = {DIMW'(r1v), DIMW'(c1v), DIMW'(r2v), DIMW'(c2v)};
        exp_out.push_back(e);
        hdr(r1v, c1v, r2v, c2v);
        for (int i = 0; i < r1v * c1v; i++) begin
            send(CTRL_DATA, abase + i);
            if (i == gap_at) begin
                send(CTRL_IDLE, 0);
                send(CTRL_IDLE, 0);
            end
        end
        for (int i = 0; i < r2v * c2v; i++) begin
            if (i == r2v * c2v - 1) checkn("valid_before_last_b", int'(out_valid), 0);
            send(CTRL_DATA, bbase + i);
        end
        checkn("valid_after_last_b", int'(out_valid), 1);
    endtask

    // Monitor: compare against the scoreboard on each rising out_valid / err.
    initial begin
        exp_t       e;
        logic [1:0] ec;
        forever begin
            @(negedge CLK);
            if (RST) begin
                mon_pv = 1'b0;
                mon_pe = 1'b0;
            end else begin
                if (out_valid && !mon_pv) begin
                    if (exp_out.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid got=1 want=0");
                    end else begin
                        e = exp_out.pop_front();
                        checkw("sb_mat_a", mat_a, e.a);
                        checkw("sb_mat_b", mat_b, e.b);
                        checkn("sb_dims", int'({r1, c1, r2, c2}), int'(e.dims));
                        checkn("sb_err_with_valid", int'(err), 0);
                    end
                end
                if (err && !mon_pe) begin
                    if (exp_err.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_err got=%0d want=none", err_code);
                    end else begin
                        ec = exp_err.pop_front();
                        checkn("sb_err_code", int'(err_code), int'(ec));
                    end
                end
                mon_pv = out_valid;
                mon_pe = err;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        ctrl      = CTRL_IDLE;
        data_in   = '0;
        out_ready = 1'b1;

        // Reset state
        #2;
        checkn("rst_out_valid", int'(out_valid), 0);
        checkn("rst_err", int'(err), 0);
        checkn("rst_err_code", int'(err_code), 0);
        checkn("rst_in_ready", int'(in_ready), 1);
        checkw("rst_mat_a", mat_a, '0);
        checkn("rst_dims", int'({r1, c1, r2, c2}), 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // 2x2 x 2x2, A=1..4, B=5..8
        load(2, 2, 2, 2, 1, 5, -1);
        checkn("t1_a_idx0", int'(mat_a[0*DW +: DW]), 1);
        checkn("t1_a_idx1", int'(mat_a[1*DW +: DW]), 2);
        checkn("t1_a_idx4", int'(mat_a[4*DW +: DW]), 3);
        checkn("t1_a_idx5", int'(mat_a[5*DW +: DW]), 4);
        checkn("t1_a_idx2_zero", int'(mat_a[2*DW +: DW]), 0);
        send(CTRL_IDLE, 0);
        checkn("t1_valid_after_hs", int'(out_valid), 0);
        checkn("t1_in_ready_after_hs", int'(in_ready), 1);

        // 3x2 x 2x4, A=1..6, B=11..18
        load(3, 2, 2, 4, 1, 11, -1);
        checkn("t2_a_idx9", int'(mat_a[9*DW +: DW]), 6);
        checkn("t2_b_idx7", int'(mat_b[7*DW +: DW]), 18);
        send(CTRL_IDLE, 0);

        // Mismatch C1 != R2
        exp_err.push_back(2'd2);
        hdr(2, 3, 2, 2);
        checkn("t3_err", int'(err), 1);
        checkn("t3_err_code", int'(err_code), 2);
        checkn("t3_in_ready", int'(in_ready), 0);
        send(CTRL_DATA, 9);
        checkn("t3_no_valid", int'(out_valid), 0);
        checkn("t3_err_sticky", int'(err), 1);
        send(CTRL_ABORT, 0);
        checkn("t3_abort_err", int'(err), 0);
        checkn("t3_abort_code", int'(err_code), 0);
        checkn("t3_abort_in_ready", int'(in_ready), 1);

        // Zero dimension
        exp_err.push_back(2'd1);
        hdr(0, 2, 2, 2);
        checkn("t3_zero_code", int'(err_code), 1);
        send(CTRL_ABORT, 0);

        // Oversize dimension with mismatch: range wins
        exp_err.push_back(2'd1);
        hdr(5, 3, 2, 2);
        checkn("t3_range_prio_code", int'(err_code), 1);
        send(CTRL_ABORT, 0);

        // Header cut short by IDLE
        exp_err.push_back(2'd3);
        send(CTRL_DIM, 2);
        send(CTRL_DIM, 2);
        send(CTRL_IDLE, 0);
        checkn("t3_short_hdr_code", int'(err_code), 3);
        send(CTRL_ABORT, 0);

        // DIM during LOAD_A
        exp_err.push_back(2'd3);
        hdr(2, 2, 2, 2);
        send(CTRL_DATA, 1);
        send(CTRL_DIM, 7);
        checkn("t3_dim_in_load_code", int'(err_code), 3);
        send(CTRL_ABORT, 0);

        // Backpressure: hold for 5 cycles while DATA/DIM are offered
        out_ready = 1'b0;
        load(2, 2, 2, 2, 21, 25, -1);
        for (int k = 0; k < 5; k++) begin
            send((k % 2) ? CTRL_DIM : CTRL_DATA, 8'hEE);
            checkn("t4_hold_valid", int'(out_valid), 1);
            checkn("t4_hold_in_ready", int'(in_ready), 0);
            checkw("t4_hold_mat_a", mat_a, build(2, 2, 21));
            checkw("t4_hold_mat_b", mat_b, build(2, 2, 25));
        end
        out_ready = 1'b1;
        send(CTRL_IDLE, 0);
        checkn("t4_release_valid", int'(out_valid), 0);
        checkn("t4_release_in_ready", int'(in_ready), 1);

        // ABORT after 3rd A element, then reload with a 2-cycle gap
        hdr(2, 2, 2, 2);
        send(CTRL_DATA, 31);
        send(CTRL_DATA, 32);
        send(CTRL_DATA, 33);
        send(CTRL_ABORT, 0);
        checkn("t5_abort_in_ready", int'(in_ready), 1);
        checkn("t5_abort_valid", int'(out_valid), 0);
        checkn("t5_abort_retains", int'(mat_a[4*DW +: DW]), 33);
        load(2, 2, 2, 2, 41, 45, 1);
        send(CTRL_IDLE, 0);

        // Async reset mid-LOAD_B
        hdr(2, 2, 2, 2);
        for (int i = 0; i < 4; i++) send(CTRL_DATA, 1 + i);
        send(CTRL_DATA, 5);
        #2;
        RST = 1'b1;
        #1;
        checkw("t6_rst_mat_a", mat_a, '0);
        checkw("t6_rst_mat_b", mat_b, '0);
        checkn("t6_rst_dims", int'({r1, c1, r2, c2}), 0);
        checkn("t6_rst_valid", int'(out_valid), 0);
        checkn("t6_rst_in_ready", int'(in_ready), 1);
        checkn("t6_rst_err", int'(err), 0);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        checkn("sb_out_drained", exp_out.size(), 0);
        checkn("sb_err_drained", exp_err.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
